// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: glyph table, polarity constants and sizing helper shared by the seven-segment display driver.
package seven_seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int         DP_BIT  = 7;

    // Active-low glyphs, bit 7 = dp, bits 6..0 = g..a; A-F use the b/d lowercase forms
    localparam logic [7:0] HEX_GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// seven_seg_hex_decode: combinational nibble + decimal point to segment pattern in the requested polarity.
module seven_seg_hex_decode
    import seven_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
)(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    logic [7:0] w_seg_al;

    always_comb begin
        w_seg_al         = HEX_GLYPH[i_nibble];
        w_seg_al[DP_BIT] = ~i_dp;
    end

    assign o_seg = ACTIVE_LOW ? w_seg_al : ~w_seg_al;

endmodule

// File: rtl/seven_seg_mux_n.sv
// seven_seg_mux_n: double-buffered multiplexed seven-segment driver with PWM brightness,
// anti-ghost gap and leading-zero suppression; outputs are registered.
module seven_seg_mux_n
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 16,
    parameter int PWM_BITS   = 3,
    parameter bit ACTIVE_LOW = 1'b1
)(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode
);

    localparam int P  = clog2(PRESCALE);
    localparam int DW = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam logic [P-1:0]          PC_LAST  = P'(PRESCALE - 1);
    localparam logic [DW-1:0]         DI_LAST  = DW'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_IDLE = ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [P-1:0]            r_pc;
    logic [DW-1:0]           r_di;
    logic                    r_pend_full;
    logic [4*NUM_DIGITS-1:0] r_pend_data, r_disp_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blank, r_disp_blank;
    logic                    r_pend_lz, r_disp_lz;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_anode;

    logic                    w_frame_end, w_accept, w_on;
    logic [NUM_DIGITS:1]     w_tail_zero;
    logic [NUM_DIGITS-1:0]   w_blank, w_anode_al;
    logic [7:0]              w_seg_dec;

    assign w_frame_end = (r_pc == PC_LAST) && (r_di == DI_LAST);
    assign w_accept    = load_valid && !r_pend_full;
    assign load_ready  = !r_pend_full;

    // w_tail_zero[i]: digit i and every digit above it show a bare zero
    always_comb begin
        w_tail_zero             = '0;
        w_tail_zero[NUM_DIGITS] = 1'b1;
        w_blank                 = r_disp_blank;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_tail_zero[i] = (r_disp_data[4*i +: 4] == 4'd0) && !r_disp_dp[i] && w_tail_zero[i+1];
            w_blank[i]     = r_disp_blank[i] || (r_disp_lz && w_tail_zero[i]);
        end
    end

    seven_seg_hex_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
        .i_nibble (r_disp_data[{r_di, 2'b00} +: 4]),
        .i_dp     (r_disp_dp[r_di]),
        .o_seg    (w_seg_dec)
    );

    assign w_on       = (r_pc != '0) && (r_pc[P-1 -: PWM_BITS] <= brightness) && !w_blank[r_di];
    assign w_anode_al = w_on ? ~(NUM_DIGITS'(1) << r_di) : {NUM_DIGITS{1'b1}};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc <= '0;
            r_di <= '0;
        end else begin
            r_pc <= r_pc + P'(1);
            if (r_pc == PC_LAST) r_di <= (r_di == DI_LAST) ? '0 : r_di + DW'(1);
        end
    end

    // Commit only at frame end so a frame never mixes old and new digits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend_full  <= 1'b0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_lz    <= 1'b0;
            r_disp_data  <= '0;
            r_disp_dp    <= '0;
            r_disp_blank <= '1;
            r_disp_lz    <= 1'b0;
        end else begin
            r_pend_full <= w_accept ? 1'b1 : (w_frame_end ? 1'b0 : r_pend_full);
            if (w_accept) begin
                r_pend_data  <= digit_data;
                r_pend_dp    <= dp;
                r_pend_blank <= blank_mask;
                r_pend_lz    <= lz_suppress;
            end
            if (w_frame_end && r_pend_full) begin
                r_disp_data  <= r_pend_data;
                r_disp_dp    <= r_pend_dp;
                r_disp_blank <= r_pend_blank;
                r_disp_lz    <= r_pend_lz;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_seg   <= SEG_IDLE;
            r_anode <= AN_IDLE;
        end else begin
            r_seg   <= w_blank[r_di] ? SEG_IDLE : w_seg_dec;
            r_anode <= ACTIVE_LOW ? w_anode_al : ~w_anode_al;
        end
    end

    assign seg   = r_seg;
    assign anode = r_anode;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// tb_seven_seg_mux_n: table-driven and randomized checks of seven_seg_mux_n against a cycle-count reference model.
module tb_seven_seg_mux_n;

    localparam int N  = 4;
    localparam int PS = 16;
    localparam int PB = 3;
    localparam int FR = N * PS;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [15:0]   digit_data = '0;
    logic [3:0]    dp = '0;
    logic [3:0]    blank_mask = '0;
    logic          lz_suppress = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [PB-1:0] brightness = '0;
    logic [7:0]    seg;
    logic [3:0]    anode;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seven_seg_mux_n #(.NUM_DIGITS(N), .PRESCALE(PS), .PWM_BITS(PB), .ACTIVE_LOW(1'b1)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .digit_data  (digit_data),
        .dp          (dp),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .brightness  (brightness),
        .seg         (seg),
        .anode       (anode)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic [31:0] segs;
        logic [3:0]  lit;
    } vec_t;

    localparam int NV = 7;
    vec_t tbl [NV];

    logic [7:0] glyph [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Reference state: edges since reset, shown and pending contents, expected outputs
    int          cnt;
    logic [15:0] m_data, p_data;
    logic [3:0]  m_dp, m_blank, p_dp, p_blank;
    logic        m_lz, p_lz, p_full;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic blanked(input int i);
        if (m_blank[i]) return 1'b1;
        if (!m_lz || i == 0) return 1'b0;
        for (int j = i; j < N; j++)
            if (m_data[4*j +: 4] != 4'd0 || m_dp[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        cnt = 0;
        m_data = '0; m_dp = '0; m_blank = '1; m_lz = 1'b0;
        p_data = '0; p_dp = '0; p_blank = '0; p_lz = 1'b0; p_full = 1'b0;
        e_seg = 8'hFF; e_an = 4'hF; e_ready = 1'b1;
    endtask

    task automatic model_step();
        int pc, di;
        logic bl;
        pc = cnt % PS;
        di = (cnt / PS) % N;
        bl = blanked(di);
        e_seg = bl ? 8'hFF : {~m_dp[di], glyph[m_data[4*di +: 4]][6:0]};
        e_an  = (!bl && pc != 0 && (pc / (PS >> PB)) <= int'(brightness)) ? ~(4'b0001 << di) : 4'hF;
        if (pc == PS - 1 && di == N - 1 && p_full) begin
            m_data = p_data; m_dp = p_dp; m_blank = p_blank; m_lz = p_lz;
            p_full = 1'b0;
        end else if (load_valid && !p_full) begin
            p_data = digit_data; p_dp = dp; p_blank = blank_mask; p_lz = lz_suppress;
            p_full = 1'b1;
        end
        e_ready = !p_full;
        cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("seg", seg, e_seg);
        check("anode", anode, e_an);
        check("load_ready", load_ready, e_ready);
    endtask

    task automatic do_load(input vec_t v);
        int b;
        digit_data = v.data; dp = v.dp; blank_mask = v.blank; lz_suppress = v.lz;
        load_valid = 1'b1;
        b = 0;
        while (!load_ready && b < 300) begin tick(); b++; end
        check("load_ready_wait", load_ready, 1);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_shown(input int d, input int pc);
        int b;
        b = 0;
        while (!(((cnt - 1) % PS) == pc && (((cnt - 1) / PS) % N) == d) && b < 300) begin tick(); b++; end
        check("wait_shown", b < 300, 1);
    endtask

    task automatic count_on(input int d, output int c);
        c = 0;
        wait_shown((d + N - 1) % N, PS - 1);
        repeat (PS) begin
            tick();
            if (!anode[d]) c++;
        end
    endtask

    initial begin
        int c, b;
        logic [3:0] ea;
        tbl[0] = '{16'h12A8, 4'b0001, 4'b0000, 1'b0, 32'hF9A48800, 4'b1111};
        tbl[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 32'hFFFF92C0, 4'b0011};
        tbl[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 32'hFFFFFFC0, 4'b0001};
        tbl[3] = '{16'h1234, 4'b0000, 4'b0100, 1'b0, 32'hF9FFB099, 4'b1011};
        tbl[4] = '{16'h0000, 4'b1000, 4'b0000, 1'b1, 32'h40C0C0C0, 4'b1111};
        tbl[5] = '{16'hBCDE, 4'b0000, 4'b0000, 1'b1, 32'h83C6A186, 4'b1111};
        tbl[6] = '{16'h0F00, 4'b0000, 4'b0000, 1'b1, 32'hFF8EC0C0, 4'b0111};

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_seg", seg, 8'hFF);
        check("reset_anode", anode, 4'hF);
        check("reset_ready", load_ready, 1);
        rstn = 1'b1;
        brightness = 3'd7;
        repeat (200) tick();
        check("idle_seg", seg, 8'hFF);
        check("idle_anode", anode, 4'hF);

        for (int k = 0; k < NV; k++) begin
            do_load(tbl[k]);
            repeat (2 * FR + 4) tick();
            for (int d = 0; d < N; d++) begin
                wait_shown(d, 8);
                ea = tbl[k].lit[d] ? ~(4'b0001 << d) : 4'hF;
                check($sformatf("vec%0d_seg_d%0d", k, d), seg, tbl[k].segs[8*d +: 8]);
                check($sformatf("vec%0d_anode_d%0d", k, d), anode, ea);
            end
        end

        do_load(tbl[0]);
        repeat (2 * FR + 4) tick();
        for (int d = 0; d < N; d++) begin
            count_on(d, c);
            check($sformatf("on_time_b7_d%0d", d), c, 15);
        end
        brightness = 3'd0;
        count_on(1, c);
        check("on_time_b0", c, 1);
        brightness = 3'd3;
        count_on(2, c);
        check("on_time_b3", c, 7);
        wait_shown(3, 5);
        brightness = 3'd7;
        repeat (FR) tick();

        do_load('{16'h1111, 4'b0000, 4'b0000, 1'b0, 32'h0, 4'h0});
        digit_data = 16'h2222;
        load_valid = 1'b1;
        b = 0;
        while (!load_ready && b < 300) begin tick(); b++; end
        check("hs_ready_after_frame_end", cnt % FR, 0);
        check("hs_stalled", b > 0, 1);
        tick();
        load_valid = 1'b0;
        wait_shown(0, 8);
        check("hs_first_value", seg, 8'hF9);
        repeat (FR) tick();
        check("hs_second_value", seg, 8'hA4);

        do_load('{16'h7777, 4'b0000, 4'b0000, 1'b0, 32'h0, 4'h0});
        do_load('{16'h8888, 4'b0000, 4'b0000, 1'b0, 32'h0, 4'h0});
        repeat (21) tick();
        check("pre_reset_ready", load_ready, 0);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check("async_reset_seg", seg, 8'hFF);
        check("async_reset_anode", anode, 4'hF);
        check("async_reset_ready", load_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        check("post_reset_ready", load_ready, 1);
        repeat (3 * FR) tick();
        check("post_reset_seg", seg, 8'hFF);
        check("post_reset_anode", anode, 4'hF);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) brightness = 3'($urandom);
            load_valid  = ($urandom_range(0, 3) == 0);
            digit_data  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & 32'h00F0);
            dp          = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            blank_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lz_suppress = 1'($urandom);
            tick();
        end
        load_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
